// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the controller state enum, the misaligned-fetch NOP and word size.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
    localparam int          WORD_BYTES  = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Fetch port and byte-stream load port of the instruction memory.
// master: PC/fetch logic and boot loader; slave: imem_loader.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [31:0]       fetch_instr;
    logic              fetch_valid;
    logic              fetch_misaligned;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr,
        output ld_start, ld_addr, ld_valid, ld_byte, ld_last,
        input  fetch_instr, fetch_valid, fetch_misaligned,
        input  ld_ready, ld_done, busy
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  ld_start, ld_addr, ld_valid, ld_byte, ld_last,
        output fetch_instr, fetch_valid, fetch_misaligned,
        output ld_ready, ld_done, busy
    );

endinterface

// File: rtl/imem_word_array.sv
// Single-port word RAM: synchronous write, registered read.
// Ports: clk_i, rst_ni, we_i, re_i, addr_i, wdata_i, rdata_o.
module imem_word_array #(
    parameter int WA = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [WA-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**WA];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register only moves on a read, so it holds between fetches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Loadable instruction memory: post-reset clear, byte-stream loader, fetch.
// Ports: clk, reset_n (async, active-low), bus (imem_loader_if.slave).
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_loader_if.slave  bus
);

    localparam int WA = ADDR_W - 2;

    state_e          state_q, state_d;
    logic [WA-1:0]   ptr_q, ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     asm_q, asm_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic            done_q, done_d;

    logic            ram_we;
    logic            ram_re;
    logic [WA-1:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic [31:0]     merged;
    logic            unused_lo;

    assign unused_lo = ^bus.ld_addr[1:0];

    // Incoming byte placed into its lane; unfilled lanes stay zero.
    assign merged = asm_q | (32'(bus.ld_byte) << {cnt_q, 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        valid_d   = 1'b0;
        mis_d     = mis_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = ptr_q;
        ram_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.ld_start) begin
                    ptr_d   = bus.ld_addr[ADDR_W-1:2];
                    cnt_d   = '0;
                    asm_d   = '0;
                    state_d = LOAD;
                end else if (bus.fetch_req) begin
                    valid_d = 1'b1;
                    if (bus.fetch_addr[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        mis_d    = 1'b0;
                        ram_re   = 1'b1;
                        ram_addr = bus.fetch_addr[ADDR_W-1:2];
                    end
                end
            end
            LOAD: begin
                ram_wdata = merged;
                if (bus.ld_valid) begin
                    if (bus.ld_last) begin
                        ram_we  = 1'b1;
                        cnt_d   = '0;
                        asm_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == 2'(WORD_BYTES - 1)) begin
                        ram_we = 1'b1;
                        ptr_d  = ptr_q + 1'b1;
                        cnt_d  = '0;
                        asm_d  = '0;
                    end else begin
                        asm_d = merged;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    imem_word_array #(
        .WA (WA)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // mis_q persists until the next fetch, so the NOP is held like data.
    assign bus.fetch_instr      = mis_q ? NOP_WORD : ram_rdata;
    assign bus.fetch_valid      = valid_q;
    assign bus.fetch_misaligned = valid_q & mis_q;
    assign bus.ld_ready         = (state_q == LOAD);
    assign bus.ld_done          = done_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads, fetch vector table,
// randomized loads/fetches against a byte-array reference model.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(
        .ADDR_W   (10),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] instr;
        logic        mis;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mref [1024];
    logic [7:0]  bq [$];
    vec_t        tbl [9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        int b;
        if (a[1:0] != 2'b00) return 32'h0000_0013;
        b = int'(a) & ~3;
        return {mref[b+3], mref[b+2], mref[b+1], mref[b]};
    endfunction

    task automatic model_clear;
        for (int i = 0; i < 1024; i++) mref[i] = 8'h00;
    endtask

    task automatic idle_inputs;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.ld_start   = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_byte    = '0;
        bus.ld_last    = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_instr"}, bus.fetch_instr, 32'h0);
        chk({tag, "_valid"}, 32'(bus.fetch_valid), 32'h0);
        chk({tag, "_mis"}, 32'(bus.fetch_misaligned), 32'h0);
        chk({tag, "_ready"}, 32'(bus.ld_ready), 32'h0);
        chk({tag, "_done"}, 32'(bus.ld_done), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
    endtask

    // Called right after reset_n rises; holds a fetch of 0x000 throughout.
    task automatic wait_clear(input string tag);
        int n = 0;
        bit idle = 0;
        bit saw = 0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = '0;
        while (n < 400 && !idle) begin
            tick;
            n++;
            if (!bus.busy) idle = 1;
            else if (bus.fetch_valid) saw = 1;
        end
        chk({tag, "_clear_cycles"}, 32'(n), 32'd256);
        chk({tag, "_valid_in_clear"}, 32'(saw), 32'h0);
        chk({tag, "_valid_at_idle"}, 32'(bus.fetch_valid), 32'h0);
        tick;
        bus.fetch_req = 1'b0;
        chk({tag, "_first_valid"}, 32'(bus.fetch_valid), 32'h1);
        chk({tag, "_first_instr"}, bus.fetch_instr, 32'h0);
    endtask

    task automatic fetch_one(input logic [9:0] a, input string nm);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick;
        bus.fetch_req = 1'b0;
        chk({nm, "_valid"}, 32'(bus.fetch_valid), 32'h1);
        chk({nm, "_instr"}, bus.fetch_instr, ref_word(a));
        chk({nm, "_mis"}, 32'(bus.fetch_misaligned), 32'(a[1:0] != 2'b00));
    endtask

    task automatic set_bytes(input logic [63:0] v, input int n);
        bq = {};
        for (int i = 0; i < n; i++) bq.push_back(v[8*i +: 8]);
    endtask

    // Loads bq at base; rnd adds valid gaps and ignored start/fetch noise.
    task automatic do_load(input logic [9:0] base, input bit rnd,
                           input string nm);
        int n = bq.size();
        int a = int'(base) & ~3;
        int k;
        bus.ld_start   = 1'b1;
        bus.ld_addr    = base;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 10'(a);
        tick;
        bus.ld_start  = 1'b0;
        bus.fetch_req = 1'b0;
        chk({nm, "_start_prio"}, 32'(bus.fetch_valid), 32'h0);
        chk({nm, "_busy_load"}, 32'(bus.busy), 32'h1);
        for (int i = 0; i < n; i++) begin
            while (rnd && $urandom_range(0, 3) == 0) begin
                bus.ld_valid   = 1'b0;
                bus.ld_start   = 1'($urandom);
                bus.fetch_req  = 1'($urandom);
                bus.fetch_addr = 10'($urandom);
                tick;
                chk({nm, "_gap_fetch"}, 32'(bus.fetch_valid), 32'h0);
            end
            bus.ld_valid = 1'b1;
            bus.ld_byte  = bq[i];
            bus.ld_last  = (i == n - 1);
            bus.ld_start = rnd ? 1'($urandom) : 1'b0;
            chk({nm, "_ready"}, 32'(bus.ld_ready), 32'h1);
            tick;
        end
        bus.ld_valid   = 1'b0;
        bus.ld_last    = 1'b0;
        bus.ld_start   = 1'b0;
        for (int i = 0; i < n; i++) mref[(a + i) % 1024] = bq[i];
        k = n;
        while (k % 4 != 0) begin
            mref[(a + k) % 1024] = 8'h00;
            k++;
        end
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 10'(a);
        chk({nm, "_done"}, 32'(bus.ld_done), 32'h1);
        chk({nm, "_busy_done"}, 32'(bus.busy), 32'h0);
        chk({nm, "_ready_done"}, 32'(bus.ld_ready), 32'h0);
        tick;
        bus.fetch_req = 1'b0;
        chk({nm, "_done_once"}, 32'(bus.ld_done), 32'h0);
        chk({nm, "_rb_valid"}, 32'(bus.fetch_valid), 32'h1);
        chk({nm, "_rb_instr"}, bus.fetch_instr, ref_word(10'(a)));
    endtask

    initial begin
        tbl[0] = '{10'h010, 32'h0050_0093, 1'b0};
        tbl[1] = '{10'h006, 32'h0000_0013, 1'b1};
        tbl[2] = '{10'h020, 32'h00CC_BBAA, 1'b0};
        tbl[3] = '{10'h3FC, 32'h0403_0201, 1'b0};
        tbl[4] = '{10'h000, 32'h0807_0605, 1'b0};
        tbl[5] = '{10'h3FE, 32'h0000_0013, 1'b1};
        tbl[6] = '{10'h024, 32'h0000_0000, 1'b0};
        tbl[7] = '{10'h018, 32'h0000_0000, 1'b0};
        tbl[8] = '{10'h014, 32'h0010_0513, 1'b0};

        idle_inputs();
        model_clear();
        #2 reset_n = 1'b0;
        #1 check_reset_vals("por");
        tick;
        tick;
        reset_n = 1'b1;
        wait_clear("por");

        set_bytes(64'h0010_0513_0050_0093, 8);
        do_load(10'h010, 1'b0, "ld010");
        set_bytes(64'h0000_0000_00CC_BBAA, 3);
        do_load(10'h020, 1'b0, "ld020");
        set_bytes(64'h0807_0605_0403_0201, 8);
        do_load(10'h3FE, 1'b0, "ld3fc");

        for (int i = 0; i < 9; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = tbl[i].addr;
            tick;
            chk($sformatf("tbl%0d_valid", i), 32'(bus.fetch_valid), 32'h1);
            chk($sformatf("tbl%0d_instr", i), bus.fetch_instr, tbl[i].instr);
            chk($sformatf("tbl%0d_mis", i), 32'(bus.fetch_misaligned),
                32'(tbl[i].mis));
        end
        bus.fetch_req = 1'b0;
        tick;
        chk("hold_valid", 32'(bus.fetch_valid), 32'h0);
        chk("hold_instr", bus.fetch_instr, 32'h0010_0513);

        for (int r = 0; r < 25; r++) begin
            logic [31:0] rv;
            logic [9:0]  fa;
            bq = {};
            for (int i = 0; i < $urandom_range(1, 9); i++)
                bq.push_back(8'($urandom));
            do_load(10'($urandom), 1'b1, $sformatf("rld%0d", r));
            for (int f = 0; f < 3; f++) begin
                rv = $urandom;
                fa = rv[9:0];
                if (rv[12:11] != 2'b00) fa[1:0] = 2'b00;
                fetch_one(fa, $sformatf("rf%0d_%0d", r, f));
            end
        end

        set_bytes(64'h0000_0000_DEAD_BEEF, 4);
        do_load(10'h040, 1'b0, "ld040");
        fetch_one(10'h040, "pre_rst");
        bus.ld_start = 1'b1;
        bus.ld_addr  = 10'h040;
        tick;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_byte  = 8'h11;
        tick;
        bus.ld_byte  = 8'h22;
        tick;
        bus.ld_byte  = 8'h33;
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid_load");
        model_clear();
        idle_inputs();
        tick;
        tick;
        reset_n = 1'b1;
        wait_clear("rerun");
        fetch_one(10'h040, "post_rst_040");
        fetch_one(10'h010, "post_rst_010");
        chk("post_rst_zero", bus.fetch_instr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
